// File: rtl/sync_fifo_flex_if.sv
// rtl/sync_fifo_flex_if.sv - handshake/status bundle for sync_fifo_flex
// Purpose: groups the producer/consumer side signals of sync_fifo_flex.
// Signals:
//   write, data_in      - write request and data (driven by master)
//   read                - read request (driven by master)
//   clear_err           - clears sticky overflow/underflow (driven by master)
//   data_out            - read data (driven by FIFO)
//   fifo_empty/full     - count == 0 / count == DEPTH
//   almost_full/empty   - count >= AF_THRESH / count <= AE_THRESH
//   fifo_counter        - occupancy 0..DEPTH
//   overflow/underflow  - sticky rejected-write / rejected-read flags
interface sync_fifo_flex_if #(
   parameter int WIDTH      = 16,
   parameter int DEPTH_BITS = 5
);
   logic                  write;
   logic [WIDTH-1:0]      data_in;
   logic                  read;
   logic                  clear_err;
   logic [WIDTH-1:0]      data_out;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  almost_full;
   logic                  almost_empty;
   logic [DEPTH_BITS:0]   fifo_counter;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output write, data_in, read, clear_err,
      input  data_out, fifo_empty, fifo_full, almost_full, almost_empty,
             fifo_counter, overflow, underflow
   );

   modport slave (
      input  write, data_in, read, clear_err,
      output data_out, fifo_empty, fifo_full, almost_full, almost_empty,
             fifo_counter, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - parametrised single-clock FIFO with thresholds, sticky errors and optional FWFT
// Purpose: generic single-clock buffer between producer and consumer blocks.
// Ports:
//   clk   - clock, all logic on rising edge
//   reset - synchronous, active-high; empties the FIFO (memory contents kept)
//   bus   - sync_fifo_flex_if.slave: write/data_in/read/clear_err in;
//           data_out, fifo_empty, fifo_full, almost_full, almost_empty,
//           fifo_counter, overflow, underflow out
module sync_fifo_flex #(
   parameter int WIDTH      = 16,
   parameter int DEPTH_BITS = 5,
   parameter int AF_THRESH  = (1 << DEPTH_BITS) - 2,
   parameter int AE_THRESH  = 2,
   parameter bit FWFT       = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   sync_fifo_flex_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] DEPTH_C = (DEPTH_BITS+1)'(DEPTH);
   localparam logic [DEPTH_BITS:0] AF_C    = (DEPTH_BITS+1)'(AF_THRESH);
   localparam logic [DEPTH_BITS:0] AE_C    = (DEPTH_BITS+1)'(AE_THRESH);

   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_flex: AF_THRESH must be in 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_flex: AE_THRESH must be in 0..DEPTH-1");
   end

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr;
   logic [DEPTH_BITS-1:0] rd_ptr;
   logic [DEPTH_BITS:0]   count;
   logic                  ovf_q;
   logic                  unf_q;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  is_empty;
   logic                  is_full;

   assign is_empty = (count == '0);
   assign is_full  = (count == DEPTH_C);

   // A write into a full FIFO is still taken when a read frees the slot in the same cycle.
   assign rd_acc = bus.read && !is_empty;
   assign wr_acc = bus.write && (!is_full || rd_acc);

   // Storage is not reset; writes are simply suppressed while reset is high.
   always_ff @(posedge clk) begin
      if (wr_acc && !reset) begin
         mem[wr_ptr] <= bus.data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // A fresh error beats clear_err in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (bus.write && !wr_acc) begin
            ovf_q <= 1'b1;
         end else if (bus.clear_err) begin
            ovf_q <= 1'b0;
         end
         if (bus.read && !rd_acc) begin
            unf_q <= 1'b1;
         end else if (bus.clear_err) begin
            unf_q <= 1'b0;
         end
      end
   end

   if (FWFT) begin : g_fwft
      // Head word is presented directly; zero while there is nothing to present.
      assign bus.data_out = is_empty ? '0 : mem[rd_ptr];
   end else begin : g_std
      logic [WIDTH-1:0] data_q;

      // mem[rd_ptr] is sampled before any same-edge write, so a full FIFO
      // doing read+write returns the oldest word.
      always_ff @(posedge clk) begin
         if (reset) begin
            data_q <= '0;
         end else if (rd_acc) begin
            data_q <= mem[rd_ptr];
         end
      end
      assign bus.data_out = data_q;
   end

   assign bus.fifo_empty   = is_empty;
   assign bus.fifo_full    = is_full;
   assign bus.almost_full  = (count >= AF_C);
   assign bus.almost_empty = (count <= AE_C);
   assign bus.fifo_counter = count;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;
endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO, next generation of the team's fixed 16x32 synchronous FIFO. Adds configurable width/depth, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a correctly sized occupancy counter and an optional first-word-fall-through (FWFT) read mode. Used as the generic buffering element between producer/consumer blocks in a single clock domain.

## Interface
- WIDTH, 16, data word width in bits
- DEPTH_BITS, 5, log2 of depth; DEPTH = 2**DEPTH_BITS
- AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH; legal 1..DEPTH
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH; legal 0..DEPTH-1
- FWFT, 0, 0 = registered standard read; 1 = first-word-fall-through
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- write  in  1  write request
- data_in  in  WIDTH  write data
- read  in  1  read request
- data_out  out  WIDTH  read data
- fifo_empty  out  1  count == 0
- fifo_full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- fifo_counter  out  DEPTH_BITS+1  occupancy 0..DEPTH
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected
- clear_err  in  1  clears overflow/underflow

## Operation
- Reset: wr_ptr, rd_ptr, count = 0; fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, overflow=0, underflow=0, data_out=0. Memory contents not reset.
- Read accepted (rd_acc) iff read && !fifo_empty. Write accepted (wr_acc) iff write && (!fifo_full || rd_acc).
- wr_acc: mem[wr_ptr] <= data_in, wr_ptr increments modulo DEPTH. rd_acc: rd_ptr increments modulo DEPTH.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- Full + read + write: both accepted; read returns the oldest word (pre-write value of the shared slot); count stays DEPTH.
- Empty + read + write: write accepted, read rejected, underflow set; count becomes 1.
- Rejected write: memory, wr_ptr, count unchanged; overflow <= 1. Rejected read: rd_ptr, count, data_out unchanged; underflow <= 1.
- clear_err clears both sticky flags; a new error in the same cycle as clear_err wins (flag stays 1).
- FWFT=0: data_out <= mem[rd_ptr] on rd_acc, otherwise holds.
- FWFT=1: data_out = mem[rd_ptr] combinationally while !fifo_empty, 0 while empty; read pops the presented word.
- All flags are decoded from the registered count (no combinational path from write/read to flags).
- Illegal AF_THRESH/AE_THRESH values cause an elaboration-time error.

## Timing
- Write accepted at edge n: fifo_counter and flags reflect it after edge n.
- FWFT=0 read latency: 1 cycle (data valid after the accepting edge).
- FWFT=1: word written into empty FIFO at edge n visible on data_out after edge n, with fifo_empty=0.
- Error flags set after the edge of the rejected request.
- Reset asserted mid-operation: all state returns to reset values at the next edge, regardless of write/read; FIFO logically emptied.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Reset with write=1, read=1 held -> after edge: fifo_empty=1, fifo_full=0, almost_empty=1, fifo_counter=0, data_out=0, no errors.
- Defaults, 32 writes of 0..31 -> almost_full rises after 30th, fifo_full and counter=32 after 32nd; 33rd write (read=0) -> overflow=1, counter 32, wr_ptr stable; clear_err -> overflow=0.
- Drain 32 reads -> data_out 0..31 in order one cycle after each read, almost_empty rises at count 2, empty at 0; 33rd read -> underflow=1, data_out holds 31.
- Full, simultaneous write 0x1234 and read for one cycle -> counter stays 32, fifo_full stays 1, data_out=0; 0x1234 emerges after 31 further reads.
- Empty, simultaneous write 0x00FF and read -> counter=1, underflow=1, next read returns 0x00FF.
- FWFT=1, DEPTH_BITS=3, WIDTH=8: write 0xA5 into empty -> next cycle data_out=0xA5, fifo_empty=0 without read; 20 interleaved write/read cycles wrap pointers with data order preserved; reset mid-stream -> empty, data_out=0.
